// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial adder/subtractor datapath.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Number of chunk steps per operation; a zero chunk is reported elsewhere
   function automatic int chunks(input int bits, input int chunk);
      return (chunk < 1) ? 1 : bits / chunk;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in; also reports the carry into its MSB.
module chunk_adder #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out,
   output logic             c_msb
);

   logic [CHUNK:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
   assign sum   = total[CHUNK-1:0];
   assign c_out = total[CHUNK];
   // The sum bit is a^b^cin, so the carry that entered the MSB falls out by XOR
   assign c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor working CHUNK bits per clock with ready/valid handshakes.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed overflow flag output.
module serial_adder
   import adder_pkg::*;
#(
   parameter int BITS  = 8,
   parameter int CHUNK = 2
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [BITS-1:0] i_augend,
   input  logic [BITS-1:0] i_addend,
   input  logic            i_subtract,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [BITS-1:0] o_sum,
   output logic            o_carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic            o_overflow
`endif
);

   localparam int N  = chunks(BITS, CHUNK);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (CHUNK < 1) begin : g_chunk_check
      $error("serial_adder: CHUNK must be at least 1");
   end else if (BITS % CHUNK != 0) begin : g_bits_check
      $error("serial_adder: BITS must be a multiple of CHUNK");
   end

   state_t          state;
   state_t          next_state;
   logic [BITS-1:0] aug_q;
   logic [BITS-1:0] add_q;
   logic [BITS-1:0] sum_q;
   logic            carry_q;
   logic [CW-1:0]   cnt;
   logic            last_chunk;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_out;

   assign last_chunk = (cnt == CW'(N - 1));
   assign a_chunk    = aug_q[int'(cnt) * CHUNK +: CHUNK];
   assign b_chunk    = add_q[int'(cnt) * CHUNK +: CHUNK];

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic c_msb;
   logic ovf_q;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a     (a_chunk),
      .b     (b_chunk),
      .c_in  (carry_q),
      .sum   (s_chunk),
      .c_out (c_out),
      .c_msb (c_msb)
   );

   assign o_overflow = ovf_q;
`else
   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a     (a_chunk),
      .b     (b_chunk),
      .c_in  (carry_q),
      .sum   (s_chunk),
      .c_out (c_out),
      .c_msb ()
   );
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      o_ready    = (state == IDLE);
      o_valid    = (state == DONE);
      case (state)
         IDLE:    if (i_valid) next_state = BUSY;
         BUSY:    if (last_chunk) next_state = DONE;
         DONE:    if (i_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Subtraction is augend + ~addend + 1, so the inversion and the +1 happen at accept
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         aug_q   <= '0;
         add_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else if (state == IDLE && i_valid) begin
         aug_q   <= i_augend;
         add_q   <= (i_subtract == MODE_SUB) ? ~i_addend : i_addend;
         carry_q <= i_subtract;
         cnt     <= '0;
      end else if (state == BUSY) begin
         sum_q[int'(cnt) * CHUNK +: CHUNK] <= s_chunk;
         carry_q <= c_out;
         if (!last_chunk) cnt <= cnt + 1'b1;
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         ovf_q <= 1'b0;
      end else if (state == BUSY && last_chunk) begin
         ovf_q <= c_msb ^ c_out;
      end
   end
`endif

   assign o_sum   = sum_q;
   assign o_carry = carry_q;

endmodule
